// File: rtl/mul_div_pkg.sv
// rtl/mul_div_pkg.sv - shared op encoding, divider state enum and op decode helpers
package mul_div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } div_state_e;

    function automatic logic is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 non-restoring division iteration
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic            q_bit,
    output logic [XLEN:0]   rem_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] divisor_ext;

    // The shift may wrap in XLEN+1 bits; the add/sub brings it back into range.
    always_comb begin
        shifted     = {rem_in[XLEN-1:0], dividend_bit};
        divisor_ext = {1'b0, divisor};
        if (rem_in[XLEN]) begin
            rem_out = shifted + divisor_ext;
        end else begin
            rem_out = shifted - divisor_ext;
        end
        q_bit = ~rem_out[XLEN];
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle RV32M/RV64M divider; DIV_REM_FUSE_EN enables DIV/REM result reuse
import mul_div_pkg::*;

module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            signed_q, signed_d;
    logic            rem_op_q, rem_op_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic [XLEN-1:0] abs_b_q, abs_b_d;
    logic [XLEN:0]   prem_q, prem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] res_q, res_d;

    logic            in_signed, in_rem, a_neg, b_neg, div_zero, overflow, fuse_hit;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            step_q_bit;
    logic [XLEN:0]   step_rem, rem_fixed;
    logic [XLEN-1:0] quo_final, rem_final;

`ifdef DIV_REM_FUSE_EN
    logic            fz_valid_q, fz_valid_d;
    logic [XLEN-1:0] fz_a_q, fz_a_d, fz_b_q, fz_b_d;
    logic            fz_signed_q, fz_signed_d;
    logic            fz_rem_op_q, fz_rem_op_d;
    logic [XLEN-1:0] fz_quo_q, fz_quo_d, fz_rem_q, fz_rem_d;
`endif

    // Quotient bits shift in from the bottom of quo_q as dividend bits leave the top.
    div_step #(.XLEN(XLEN)) u_step (
        .rem_in       (prem_q),
        .dividend_bit (quo_q[XLEN-1]),
        .divisor      (abs_b_q),
        .q_bit        (step_q_bit),
        .rem_out      (step_rem)
    );

    always_comb begin
        in_signed = is_signed(in_op);
        in_rem    = is_rem(in_op);
        a_neg     = in_signed & in_a[XLEN-1];
        b_neg     = in_signed & in_b[XLEN-1];
        abs_a     = a_neg ? -in_a : in_a;
        abs_b     = b_neg ? -in_b : in_b;
        div_zero  = (in_b == '0);
        overflow  = in_signed && (in_a == MIN_NEG) && (in_b == '1);
`ifdef DIV_REM_FUSE_EN
        fuse_hit  = fz_valid_q && (in_a == fz_a_q) && (in_b == fz_b_q) &&
                    (in_signed == fz_signed_q) && (in_rem != fz_rem_op_q);
`else
        fuse_hit  = 1'b0;
`endif
        rem_fixed = prem_q[XLEN] ? (prem_q + {1'b0, abs_b_q}) : prem_q;
        quo_final = (signed_q && (sign_a_q ^ sign_b_q)) ? -quo_q : quo_q;
        rem_final = (signed_q && sign_a_q) ? -rem_fixed[XLEN-1:0] : rem_fixed[XLEN-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        signed_d = signed_q;
        rem_op_d = rem_op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        abs_b_d  = abs_b_q;
        prem_d   = prem_q;
        quo_d    = quo_q;
        res_d    = res_q;
`ifdef DIV_REM_FUSE_EN
        fz_valid_d  = fz_valid_q;
        fz_a_d      = fz_a_q;
        fz_b_d      = fz_b_q;
        fz_signed_d = fz_signed_q;
        fz_rem_op_d = fz_rem_op_q;
        fz_quo_d    = fz_quo_q;
        fz_rem_d    = fz_rem_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    signed_d = in_signed;
                    rem_op_d = in_rem;
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    abs_b_d  = abs_b;
                    quo_d    = abs_a;
                    prem_d   = '0;
                    cnt_d    = '0;
                    if (div_zero || overflow) begin
                        if (div_zero) begin
                            res_d = in_rem ? in_a : '1;
                        end else begin
                            res_d = in_rem ? '0 : in_a;
                        end
                        state_d = ST_DONE;
`ifdef DIV_REM_FUSE_EN
                        fz_valid_d = 1'b0;
`endif
                    end else if (fuse_hit) begin
`ifdef DIV_REM_FUSE_EN
                        res_d = in_rem ? fz_rem_q : fz_quo_q;
`endif
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
`ifdef DIV_REM_FUSE_EN
                        fz_valid_d  = 1'b0;
                        fz_a_d      = in_a;
                        fz_b_d      = in_b;
                        fz_signed_d = in_signed;
                        fz_rem_op_d = in_rem;
`endif
                    end
                end
            end
            ST_CALC: begin
                prem_d = step_rem;
                quo_d  = {quo_q[XLEN-2:0], step_q_bit};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                res_d   = rem_op_q ? rem_final : quo_final;
                state_d = ST_DONE;
`ifdef DIV_REM_FUSE_EN
                fz_valid_d = 1'b1;
                fz_quo_d   = quo_final;
                fz_rem_d   = rem_final;
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush aborts like reset but keeps the last result visible.
        if (flush) begin
            state_d = ST_IDLE;
`ifdef DIV_REM_FUSE_EN
            fz_valid_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            signed_q <= 1'b0;
            rem_op_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            abs_b_q  <= '0;
            prem_q   <= '0;
            quo_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
            rem_op_q <= rem_op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            abs_b_q  <= abs_b_d;
            prem_q   <= prem_d;
            quo_q    <= quo_d;
            res_q    <= res_d;
        end
    end

`ifdef DIV_REM_FUSE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fz_valid_q  <= 1'b0;
            fz_a_q      <= '0;
            fz_b_q      <= '0;
            fz_signed_q <= 1'b0;
            fz_rem_op_q <= 1'b0;
            fz_quo_q    <= '0;
            fz_rem_q    <= '0;
        end else begin
            fz_valid_q  <= fz_valid_d;
            fz_a_q      <= fz_a_d;
            fz_b_q      <= fz_b_d;
            fz_signed_q <= fz_signed_d;
            fz_rem_op_q <= fz_rem_op_d;
            fz_quo_q    <= fz_quo_d;
            fz_rem_q    <= fz_rem_d;
        end
    end
`endif

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_result = res_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 non-restoring integer divider; the inverse companion of the prefix-adder multiplier in the MUL/DIV execution unit.
- Implements RV32M/RV64M DIV, DIVU, REM and REMU with exact RISC-V corner-case semantics.
- Sits beside the multiplier behind the same execute-stage valid/ready handshake.
- Accepts one operation at a time and returns one XLEN-wide result.

Parameters:
- XLEN, 32, operand and result width; must be 32 or 64.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  pipeline kill; aborts the in-flight operation.
- in_valid  input  1  request valid.
- in_ready  output  1  high only in IDLE.
- in_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- in_a  input  XLEN  dividend.
- in_b  input  XLEN  divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  XLEN  quotient or remainder, as selected by in_op.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, busy=0. Reset mid-operation discards all state within one cycle.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Accept when in_valid && in_ready; latch in_op, |a|, |b|, and the signs of a and b (signed ops only); clear the iteration counter.
  - Special cases go directly to DONE, result registered in the accept cycle:
    - b==0: quotient = all ones; remainder = a.
    - Signed overflow (a = 1<<(XLEN-1), b = all ones): quotient = a; remainder = 0.
  - Otherwise go to CALC.
- CALC:
  - One quotient bit per cycle, exactly XLEN cycles, counter 0..XLEN-1.
  - Partial remainder is XLEN+1 bits, two's complement.
  - Partial remainder >= 0: shift left and subtract |b|. Partial remainder < 0: shift left and add |b|.
  - Quotient bit = NOT sign of the new remainder.
  - Counter == XLEN-1 -> FIX.
- FIX (1 cycle):
  - Restore a negative final remainder by adding |b|.
  - Negate the quotient if sign_a ^ sign_b (signed ops).
  - Negate the remainder if sign_a (signed ops).
  - Register the selected result; go to DONE.
- DONE:
  - out_valid=1; out_result held stable until out_ready.
  - out_valid && out_ready -> IDLE. A new request is not accepted in the same cycle.
- Latency, from the accept edge to out_valid:
  - Normal: XLEN+2 cycles (XLEN CALC + FIX + register).
  - Special cases: 1 cycle.
- flush: in any state, next state IDLE and out_valid=0. flush wins over a simultaneous accept. flush and rst behave identically except the result register is not cleared by flush.
- out_ready is ignored outside DONE.
- Inputs are sampled only at accept. Changes to in_a, in_b or in_op afterwards have no effect.

Optional Feature:
- Macro: DIV_REM_FUSE_EN.
- With the macro defined:
  - The unit retains the last completed operands, signedness, quotient and remainder, plus a valid bit.
  - The valid bit is cleared by rst, by flush, and by any special-case result.
  - An accepted request with identical in_a, in_b and signedness, and a different quotient/remainder select, bypasses CALC and goes to DONE in 1 cycle with the stored value (e.g. DIV then REM).
- Without the macro: no operand storage; every non-special operation takes XLEN+2 cycles.

Decomposition:
- Shared package mul_div_pkg holds:
  - the in_op encoding constants (OP_DIV, OP_DIVU, OP_REM, OP_REMU);
  - the state enum;
  - function is_signed(op) and function is_rem(op).
- Natural sub-module: div_step. Combinational; computes one non-restoring iteration (remainder-in, divisor, quotient bit, remainder-out) and is instantiated once inside CALC.
- Controller and counter stay in div_unit.

Test Plan:
- DIVU 100/7, XLEN=32 -> out_valid exactly 34 cycles after accept; result 14. REMU same operands -> 2.
- DIV -7/2 -> -3 (0xFFFFFFFD). REM -7/2 -> -1. REM 7/-2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF after 1 cycle. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Backpressure: out_ready low for 5 cycles in DONE -> out_result stable, in_ready low; out_ready high -> IDLE next cycle.
- flush at CALC counter 10 -> IDLE next cycle, no out_valid. rst asserted mid-CALC -> all outputs at reset values the following cycle.
- With DIV_REM_FUSE_EN: DIVU 1000/9 (111 after 34 cycles) then REMU 1000/9 -> 1 after 1 cycle. An intervening flush forces the full 34-cycle path.
